// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single 128-bit line memory.
// Sequences the memory req/ready handshake, captures read lines and aborts hung accesses.
module mem_port_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int RD_SETTLE = 1,
  parameter int TIMEOUT   = 16
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [127:0]      p0_wr_data,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [127:0]      p1_wr_data,
  output logic              p0_done,
  output logic              p0_err,
  output logic              p1_done,
  output logic              p1_err,
  output logic [127:0]      rd_data,
  output logic [1:0]        grant,
  output logic              busy,
  input  logic              loading,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wr_data,
  output logic              mem_reset_req,
  input  logic              mem_ready,
  input  logic [127:0]      mem_rd_data
);
  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, SETTLE, RESP, ABORT} state_t;

  localparam logic [1:0] SETTLE_LAST = 2'(RD_SETTLE - 1);
  localparam logic [7:0] WD_LAST     = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [1:0] grant_n;
  logic       last, last_n;  // 1 = port 1 was served last
  logic [7:0] wd;
  logic [1:0] settle;
  logic       wd_hit;

  assign busy        = (state != IDLE);
  assign wd_hit      = (wd == WD_LAST);
  assign mem_we      = (grant[0] & p0_we) | (grant[1] & p1_we);
  assign mem_addr    = ({ADDR_W{grant[0]}} & p0_addr) | ({ADDR_W{grant[1]}} & p1_addr);
  assign mem_wr_data = ({128{grant[0]}} & p0_wr_data) | ({128{grant[1]}} & p1_wr_data);

  // In BUSY, 'requested' falls the same cycle ready rises so the memory never re-triggers.
  always_comb begin
    mem_req = 1'b0;
    case (state)
      ISSUE:   mem_req = 1'b1;
      BUSY:    mem_req = !mem_ready;
      default: mem_req = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    case (state)
      IDLE: if (!loading && (p0_req || p1_req)) begin
        state_n = ISSUE;
        if (p0_req && p1_req) grant_n = last ? 2'b01 : 2'b10;
        else                  grant_n = p0_req ? 2'b01 : 2'b10;
      end
      ISSUE: begin
        if (wd_hit)          state_n = ABORT;
        else if (!mem_ready) state_n = BUSY;
      end
      BUSY: begin
        if (wd_hit)         state_n = ABORT;
        else if (mem_ready) state_n = mem_we ? RESP : SETTLE;
      end
      SETTLE: if (settle == SETTLE_LAST) state_n = RESP;
      RESP, ABORT: begin
        state_n = IDLE;
        grant_n = 2'b00;
        last_n  = grant[1];
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= 2'b00;
      last          <= 1'b1;
      wd            <= '0;
      settle        <= '0;
      rd_data       <= '0;
      p0_done       <= 1'b0;
      p1_done       <= 1'b0;
      p0_err        <= 1'b0;
      p1_err        <= 1'b0;
      mem_reset_req <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
      if (state_n == ISSUE && state != ISSUE)  wd <= '0;
      else if (state == ISSUE || state == BUSY) wd <= wd + 8'd1;
      if (state_n == SETTLE && state != SETTLE) settle <= '0;
      else if (state == SETTLE)                 settle <= settle + 2'd1;
      if (state == SETTLE && settle == SETTLE_LAST) rd_data <= mem_rd_data;
      // Pulses line up with the single RESP / ABORT cycle.
      {p1_done, p0_done} <= (state_n == RESP)  ? grant : 2'b00;
      {p1_err,  p0_err}  <= (state_n == ABORT) ? grant : 2'b00;
      mem_reset_req      <= (state_n == ABORT);
    end
  end
endmodule
